// File: rtl/fwd_scoreboard.sv
// Operand forwarding select and hazard stall for decode, with one
// tracked multi-cycle op and a saturating stall-cycle counter.
module fwd_scoreboard #(
  parameter int NSRC   = 2,
  parameter int NFWD   = 2,
  parameter int RW     = 5,
  parameter int MC_LAT = 4,
  parameter int SW     = $clog2(NFWD + 2)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic [NSRC*RW-1:0]   src_reg,
  input  logic [NSRC-1:0]      src_used,
  input  logic [RW-1:0]        dst_reg,
  input  logic                 dst_wr,
  input  logic                 issue_mc,
  input  logic [NFWD*RW-1:0]   stage_rd,
  input  logic [NFWD-1:0]      stage_wr,
  input  logic [NFWD-1:0]      stage_isload,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic                 stall,
  output logic                 mc_busy,
  output logic                 mc_done,
  output logic [31:0]          stall_cnt
);

  localparam int CW = $clog2(MC_LAT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] mc_rd;
  logic [31:0]   stall_cnt_q;
  logic [31:0]   stall_cnt_nxt;

  logic          st_busy;
  logic          st_done;
  logic          ld_hit;
  logic          raw_hit;
  logic          waw_hit;
  logic          take;
  logic          hit;
  logic [RW-1:0] sr;
  logic [SW-1:0] sel;

  // only stage 0 can hold a load whose data is still in flight
  logic unused_isload;
  assign unused_isload = ^stage_isload;

  assign st_busy = (state == S_BUSY);
  assign st_done = (state == S_DONE);
  assign mc_busy = st_busy;
  assign mc_done = st_done;

  always_comb begin
    fwd_sel = '0;
    ld_hit  = 1'b0;
    raw_hit = 1'b0;
    hit     = 1'b0;
    sr      = '0;
    sel     = '0;
    for (int s = 0; s < NSRC; s++) begin
      sr  = src_reg[s*RW +: RW];
      sel = '0;
      // scan oldest to youngest so the youngest match wins
      for (int k = NFWD - 1; k >= 0; k--) begin
        hit = src_used[s] & stage_wr[k]
            & (stage_rd[k*RW +: RW] == sr)
            & (sr != '0);
        if (hit)
          sel = SW'(k + 1);
        if ((k == 0) && hit && stage_isload[0])
          ld_hit = 1'b1;
      end
      if ((sel == '0) && st_done
          && (mc_rd == sr) && (sr != '0))
        sel = SW'(NFWD + 1);
      if (st_busy && src_used[s]
          && (sr == mc_rd) && (sr != '0))
        raw_hit = 1'b1;
      fwd_sel[s*SW +: SW] = sel;
    end
  end

  assign waw_hit = dst_wr & (dst_reg == mc_rd)
                 & (mc_rd != '0) & (st_busy | st_done);

  assign stall = ld_hit | raw_hit | waw_hit
               | (issue_mc & st_busy);

  assign take = en & ~stall & issue_mc;

  assign stall_cnt_nxt =
    (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      ? stall_cnt_q + 32'd1 : stall_cnt_q;

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mc_rd       <= '0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_nxt;
      case (state)
        S_IDLE: begin
          if (take) begin
            state <= S_BUSY;
            mc_rd <= dst_reg;
            cnt   <= CW'(MC_LAT - 1);
          end
        end
        S_BUSY: begin
          if (cnt == '0)
            state <= S_DONE;
          else
            cnt <= cnt - CW'(1);
        end
        S_DONE: begin
          if (take) begin
            state <= S_BUSY;
            mc_rd <= dst_reg;
            cnt   <= CW'(MC_LAT - 1);
          end else if (en) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios plus random traffic
// compared every cycle against a behavioural hazard model.
module tb_fwd_scoreboard;

  localparam int NSRC   = 2;
  localparam int NFWD   = 2;
  localparam int RW     = 5;
  localparam int MC_LAT = 4;
  localparam int SW     = 2;

  logic                CLK = 1'b0;
  logic                RST;
  logic                en;
  logic [NSRC*RW-1:0]  src_reg;
  logic [NSRC-1:0]     src_used;
  logic [RW-1:0]       dst_reg;
  logic                dst_wr;
  logic                issue_mc;
  logic [NFWD*RW-1:0]  stage_rd;
  logic [NFWD-1:0]     stage_wr;
  logic [NFWD-1:0]     stage_isload;
  logic [NSRC*SW-1:0]  fwd_sel;
  logic                stall;
  logic                mc_busy;
  logic                mc_done;
  logic [31:0]         stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model: cycles of busy left, done flag, pending dest, stall count
  int          m_left;
  bit          m_done;
  logic [4:0]  m_rd;
  logic [31:0] m_scnt;
  bit          m_ok = 1'b0;
  bit          e_stall;
  int          e_sel [NSRC];

  fwd_scoreboard #(
    .NSRC(NSRC), .NFWD(NFWD), .RW(RW),
    .MC_LAT(MC_LAT), .SW(SW)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en),
    .src_reg(src_reg), .src_used(src_used),
    .dst_reg(dst_reg), .dst_wr(dst_wr),
    .issue_mc(issue_mc),
    .stage_rd(stage_rd), .stage_wr(stage_wr),
    .stage_isload(stage_isload),
    .fwd_sel(fwd_sel), .stall(stall),
    .mc_busy(mc_busy), .mc_done(mc_done),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] src_of(int s);
    return src_reg[s*RW +: RW];
  endfunction

  function automatic logic [4:0] srd_of(int k);
    return stage_rd[k*RW +: RW];
  endfunction

  // Expected outputs straight from the hazard rules.
  task automatic predict();
    bit busy;
    bit ld;
    bit raw;
    bit waw;
    busy = (m_left > 0);
    ld   = 1'b0;
    raw  = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      logic [4:0] r;
      r = src_of(s);
      e_sel[s] = 0;
      for (int k = 0; k < NFWD; k++) begin
        if (src_used[s] && stage_wr[k]
            && srd_of(k) == r && r != 0) begin
          e_sel[s] = k + 1;
          if (k == 0 && stage_isload[0]) ld = 1'b1;
          break;
        end
      end
      if (e_sel[s] == 0 && m_done && m_rd == r && r != 0)
        e_sel[s] = NFWD + 1;
      if (busy && src_used[s] && r == m_rd && r != 0)
        raw = 1'b1;
    end
    waw = dst_wr && dst_reg == m_rd && m_rd != 0
          && (busy || m_done);
    e_stall = ld || raw || waw || (issue_mc && busy);
  endtask

  task automatic advance();
    if (RST) begin
      m_left = 0;
      m_done = 1'b0;
      m_rd   = '0;
      m_scnt = '0;
      m_ok   = 1'b1;
    end else begin
      if (e_stall && m_scnt != 32'hFFFF_FFFF)
        m_scnt = m_scnt + 1;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (en && !e_stall && issue_mc) begin
        m_left = MC_LAT;
        m_done = 1'b0;
        m_rd   = dst_reg;
      end else if (m_done && en) begin
        m_done = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    predict();
    if (m_ok) begin
      for (int s = 0; s < NSRC; s++)
        chk($sformatf("sel%0d", s),
            64'(fwd_sel[s*SW +: SW]), 64'(e_sel[s]));
      chk("stall", 64'(stall), 64'(e_stall));
      chk("busy", 64'(mc_busy), 64'(m_left > 0));
      chk("done", 64'(mc_done), 64'(m_done));
      chk("scnt", 64'(stall_cnt), 64'(m_scnt));
    end
    @(posedge CLK);
    advance();
    #1;
  endtask

  task automatic idle();
    en           = 1'b1;
    src_reg      = '0;
    src_used     = '0;
    dst_reg      = '0;
    dst_wr       = 1'b0;
    issue_mc     = 1'b0;
    stage_rd     = '0;
    stage_wr     = '0;
    stage_isload = '0;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 4) == 0)
      return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 3));
  endfunction

  initial begin
    RST = 1'b1;
    idle();
    cyc();
    cyc();
    RST = 1'b0;
    #1;
    chk("rst_busy", 64'(mc_busy), 64'd0);
    chk("rst_done", 64'(mc_done), 64'd0);
    chk("rst_scnt", 64'(stall_cnt), 64'd0);

    // youngest stage wins
    src_reg  = {5'd0, 5'd3};
    src_used = 2'b01;
    stage_rd = {5'd3, 5'd3};
    stage_wr = 2'b11;
    #1;
    chk("prio_sel", 64'(fwd_sel[1:0]), 64'd1);
    chk("prio_stall", 64'(stall), 64'd0);
    cyc();

    // r0 never forwards; s0 hits stage 1 only
    src_reg  = {5'd0, 5'd3};
    src_used = 2'b11;
    stage_rd = {5'd3, 5'd0};
    stage_wr = 2'b11;
    #1;
    chk("r0_sel", 64'(fwd_sel[3:2]), 64'd0);
    chk("st1_sel", 64'(fwd_sel[1:0]), 64'd2);
    chk("r0_stall", 64'(stall), 64'd0);
    cyc();

    // load-use
    idle();
    src_reg      = {5'd0, 5'd7};
    src_used     = 2'b01;
    stage_rd     = {5'd0, 5'd7};
    stage_wr     = 2'b01;
    stage_isload = 2'b01;
    #1;
    chk("lu_stall", 64'(stall), 64'd1);
    chk("lu_cnt0", 64'(stall_cnt), 64'd0);
    cyc();
    idle();
    #1;
    chk("lu_cnt1", 64'(stall_cnt), 64'd1);
    chk("lu_clr", 64'(stall), 64'd0);

    // multi-cycle op to r9
    issue_mc = 1'b1;
    dst_wr   = 1'b1;
    dst_reg  = 5'd9;
    #1;
    chk("mc_issue", 64'(stall), 64'd0);
    cyc();
    idle();
    #1;
    chk("mc_t1", 64'(mc_busy), 64'd1);
    cyc();
    src_reg  = {5'd0, 5'd9};
    src_used = 2'b01;
    #1;
    chk("mc_raw", 64'(stall), 64'd1);
    cyc();
    idle();
    cyc();
    #1;
    chk("mc_t4", 64'(mc_busy), 64'd1);
    cyc();
    src_reg  = {5'd0, 5'd9};
    src_used = 2'b01;
    #1;
    chk("mc_t5", 64'(mc_done), 64'd1);
    chk("mc_fwd", 64'(fwd_sel[1:0]), 64'(NFWD + 1));
    cyc();

    // structural stall, then issue straight from DONE
    idle();
    issue_mc = 1'b1;
    dst_wr   = 1'b1;
    dst_reg  = 5'd10;
    cyc();
    dst_reg = 5'd11;
    for (int i = 0; i < MC_LAT; i++) begin
      #1;
      chk("struct", 64'(stall), 64'd1);
      cyc();
    end
    #1;
    chk("d2b_done", 64'(mc_done), 64'd1);
    chk("d2b_go", 64'(stall), 64'd0);
    cyc();
    idle();
    src_reg  = {5'd0, 5'd11};
    src_used = 2'b01;
    #1;
    chk("d2b_busy", 64'(mc_busy), 64'd1);
    chk("d2b_newrd", 64'(stall), 64'd1);
    src_reg = {5'd0, 5'd10};
    #1;
    chk("d2b_oldrd", 64'(stall), 64'd0);
    cyc();

    // reset mid-busy abandons the op
    idle();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    #1;
    chk("rb_busy", 64'(mc_busy), 64'd0);
    chk("rb_scnt", 64'(stall_cnt), 64'd0);
    for (int i = 0; i < MC_LAT + 2; i++) cyc();
    src_reg  = {5'd0, 5'd11};
    src_used = 2'b01;
    #1;
    chk("rb_nodone", 64'(mc_done), 64'd0);
    chk("rb_nofwd", 64'(fwd_sel[1:0]), 64'd0);

    // reset beats a same-cycle issue
    idle();
    RST      = 1'b1;
    issue_mc = 1'b1;
    dst_wr   = 1'b1;
    dst_reg  = 5'd5;
    cyc();
    RST = 1'b0;
    idle();
    #1;
    chk("rst_issue", 64'(mc_busy), 64'd0);

    // saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    m_scnt = 32'hFFFF_FFFE;
    cyc();
    release dut.stall_cnt_q;
    src_reg      = {5'd0, 5'd7};
    src_used     = 2'b01;
    stage_rd     = {5'd0, 5'd7};
    stage_wr     = 2'b01;
    stage_isload = 2'b01;
    cyc();
    cyc();
    idle();
    #1;
    chk("sat", 64'(stall_cnt), 64'hFFFF_FFFF);

    RST = 1'b1;
    cyc();
    RST = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      RST          = ($urandom_range(0, 199) == 0);
      en           = ($urandom_range(0, 3) != 0);
      src_reg      = {pick(), pick()};
      src_used     = 2'($urandom_range(0, 3));
      dst_reg      = pick();
      dst_wr       = ($urandom_range(0, 1) == 0);
      issue_mc     = ($urandom_range(0, 4) == 0);
      stage_rd     = {pick(), pick()};
      stage_wr     = 2'($urandom_range(0, 3));
      stage_isload = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter NSRC, default 2, number of source operands checked per decode.
REQ-002 Parameter NFWD, default 2, number of forwarding stages ahead of decode (stage 0 youngest).
REQ-003 Parameter RW, default 5, register index width; register 0 is hardwired zero.
REQ-004 Parameter MC_LAT, default 4, multi-cycle unit latency in cycles (>=2).
REQ-005 Parameter SW, default $clog2(NFWD+2), width of each forward-select field.
REQ-006 CLK  in  1  clock, all state updates on rising edge.
REQ-007 RST  in  1  reset, synchronous, active-high.
REQ-008 en  in  1  pipeline advance; decode instruction leaves decode this cycle when en & !stall.
REQ-009 src_reg  in  NSRC*RW  decode source registers, field k = bits [k*RW +: RW].
REQ-010 src_used  in  NSRC  per-source valid.
REQ-011 dst_reg / dst_wr  in  RW / 1  decode destination and register-write flag.
REQ-012 issue_mc  in  1  decode instruction is a multi-cycle op (writes dst_reg).
REQ-013 stage_rd  in  NFWD*RW  destination register per forwarding stage.
REQ-014 stage_wr  in  NFWD  register-write flag per stage.
REQ-015 stage_isload  in  NFWD  stage holds a load whose data is not yet valid (meaningful only for stage 0).
REQ-016 fwd_sel  out  NSRC*SW  per source: 0 regfile, k+1 stage k, NFWD+1 multi-cycle result.
REQ-017 stall  out  1  hold decode, insert bubble.
REQ-018 mc_busy / mc_done  out  1 / 1  multi-cycle unit state flags.
REQ-019 stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-020 Match(k,s) SHALL be src_used[s] & stage_wr[k] & stage_rd[k]==src_reg[s] & src_reg[s]!=0.
REQ-021 fwd_sel[s] SHALL select the lowest k with Match(k,s); stages take priority over the multi-cycle result.
REQ-022 If no stage matches and state is DONE with mc_rd==src_reg[s]!=0, fwd_sel[s] SHALL be NFWD+1; otherwise 0.
REQ-023 fwd_sel and stall SHALL be combinational from current inputs and registered state.
REQ-024 Load-use: stall SHALL assert if any Match(0,s) & stage_isload[0].
REQ-025 RAW on pending op: stall SHALL assert if state BUSY and any used src_reg[s]==mc_rd!=0.
REQ-026 Structural: stall SHALL assert if issue_mc and state BUSY.
REQ-027 WAW: stall SHALL assert if dst_wr & dst_reg==mc_rd!=0 and state BUSY or DONE.
REQ-028 FSM states IDLE, BUSY, DONE; mc_busy=(BUSY), mc_done=(DONE).
REQ-029 IDLE->BUSY on en & !stall & issue_mc: latch mc_rd<=dst_reg, cnt<=MC_LAT-1.
REQ-030 BUSY: cnt SHALL decrement every cycle regardless of en; cnt==0 -> DONE next cycle.
REQ-031 DONE->IDLE on en; if en & !stall & issue_mc in DONE, go directly to BUSY with new mc_rd and cnt; DONE held while !en.
REQ-032 Total issue-to-DONE latency SHALL be exactly MC_LAT cycles with no stall.
REQ-033 stall_cnt SHALL increment by 1 each cycle stall=1, saturate at 32'hFFFF_FFFF, never wrap.
REQ-034 Stall from multiple causes in one cycle SHALL count once.

Reset
REQ-035 On RST: state IDLE, cnt 0, mc_rd 0, stall_cnt 0; thus mc_busy=0, mc_done=0.
REQ-036 RST mid-BUSY SHALL abandon the pending op; no DONE, no forwarding of it.
REQ-037 RST SHALL override same-cycle issue_mc.

Verification
REQ-038 src_reg0=3, stage_rd0=3 wr, stage_rd1=3 wr, no load -> fwd_sel0=1 (stage 0 wins), stall=0.
REQ-039 src_reg1=0, stage_rd0=0 wr -> fwd_sel1=0, stall=0.
REQ-040 src_reg0=7 matches stage 0 with stage_isload[0]=1 -> stall=1 one cycle; stall_cnt 0->1.
REQ-041 issue_mc dst=9 at t0, en=1, MC_LAT=4 -> BUSY t1..t4, DONE t5; src=9 at t2 stalls; src=9 at t5 -> fwd_sel=NFWD+1.
REQ-042 issue_mc during BUSY -> stall until DONE; issue in DONE with en -> BUSY next cycle, new mc_rd.
REQ-043 RST at BUSY cnt=2 -> IDLE next cycle, mc_busy=0, stall_cnt=0; preload stall_cnt FFFF_FFFE, two stall cycles -> stays FFFF_FFFF.
